// File: rtl/per2apb.sv
// Bridge from the per req/gnt/r_valid protocol onto an APB3 master port.
// One transaction in flight; responses carry read data, error flag and echoed ID.
module per2apb #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d, add_ext;
    logic                      we_q, we_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [PER_ID_WIDTH-1:0]   id_q, id_d;
    logic [PER_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      opc_q, opc_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      timeout_hit;

    generate
        if (APB_ADDR_WIDTH > PER_ADDR_WIDTH) begin : g_addr_zext
            assign add_ext = {{(APB_ADDR_WIDTH - PER_ADDR_WIDTH){1'b0}}, per_slave_add_i};
        end else begin : g_addr_trunc
            assign add_ext = per_slave_add_i[APB_ADDR_WIDTH-1:0];
        end
    endgenerate

    // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees PREADY low.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        id_d            = id_q;
        rid_d           = rid_q;
        rdata_d         = rdata_q;
        opc_d           = opc_q;
        cnt_d           = cnt_q;
        per_slave_gnt_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                per_slave_gnt_o = per_slave_req_i;
                if (per_slave_req_i) begin
                    addr_d  = add_ext;
                    we_d    = per_slave_we_i;
                    wdata_d = per_slave_we_i ? per_slave_wdata_i : 32'h0;
                    id_d    = per_slave_id_i;
                    // No strobes on APB3: partial writes are refused without a bus access.
                    if (per_slave_we_i && (per_slave_be_i != 4'hF)) begin
                        opc_d   = 1'b1;
                        rdata_d = 32'h0;
                        rid_d   = per_slave_id_i;
                        state_d = StResp;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    rdata_d = we_q ? 32'h0 : PRDATA;
                    opc_d   = PSLVERR;
                    rid_d   = id_q;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = 32'hDEAD_BEEF;
                    opc_d   = 1'b1;
                    rid_d   = id_q;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            opc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            rdata_q <= rdata_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PSEL                = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE             = (state_q == StAccess);
    assign PADDR               = addr_q;
    assign PWRITE              = we_q;
    assign PWDATA              = wdata_q;
    assign per_slave_r_valid_o = (state_q == StResp);
    assign per_slave_r_opc_o   = opc_q;
    assign per_slave_r_id_o    = rid_q;
    assign per_slave_r_rdata_o = rdata_q;

endmodule

// File: tb/tb_per2apb.sv
// Randomized and directed checks of per2apb against a transaction-level model
// that predicts response cycle, APB phase timing and response contents.
module tb_per2apb;

    localparam int unsigned Tmo = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic        gnt, r_valid, r_opc;
    logic [4:0]  r_id;
    logic [31:0] r_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour knobs
    int          slv_waits = 0;
    int          acc_n     = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;

    per2apb #(
        .PER_ADDR_WIDTH(32),
        .APB_ADDR_WIDTH(32),
        .PER_ID_WIDTH  (5),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .per_slave_req_i    (req),
        .per_slave_add_i    (add),
        .per_slave_we_i     (we),
        .per_slave_wdata_i  (wdata),
        .per_slave_be_i     (be),
        .per_slave_id_i     (id),
        .per_slave_gnt_o    (gnt),
        .per_slave_r_valid_o(r_valid),
        .per_slave_r_opc_o  (r_opc),
        .per_slave_r_id_o   (r_id),
        .per_slave_r_rdata_o(r_rdata),
        .PADDR              (PADDR),
        .PWDATA             (PWDATA),
        .PWRITE             (PWRITE),
        .PSEL               (PSEL),
        .PENABLE            (PENABLE),
        .PRDATA             (PRDATA),
        .PREADY             (PREADY),
        .PSLVERR            (PSLVERR)
    );

    always #5 clk_i = ~clk_i;

    // APB slave: ready after slv_waits wait states of the ACCESS phase.
    always @(negedge clk_i) begin
        PRDATA  = slv_rdata;
        PSLVERR = slv_err;
        if (PSEL && PENABLE) begin
            PREADY = (acc_n == slv_waits);
            acc_n  = acc_n + 1;
        end else begin
            PREADY = 1'b0;
            acc_n  = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle.
    task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] b, input logic [4:0] i, input int waits,
                           input logic [31:0] prd, input logic err);
        bit          partial, tmo;
        int          resp;
        logic [31:0] exp_rd;
        logic        exp_opc;
        partial = w && (b != 4'hF);
        tmo     = !partial && (waits >= int'(Tmo));
        resp    = partial ? 1 : (tmo ? 2 + int'(Tmo) : 3 + waits);
        exp_rd  = partial ? 32'h0 : (tmo ? 32'hDEAD_BEEF : (w ? 32'h0 : prd));
        exp_opc = partial || tmo || err;
        slv_waits = waits;
        slv_rdata = prd;
        slv_err   = err;
        req = 1'b1; add = a; we = w; wdata = wd; be = b; id = i;
        for (int c = 0; c <= resp + 1; c++) begin
            @(negedge clk_i);
            check_eq("gnt", 64'(gnt), 64'(c == 0));
            check_eq("psel", 64'(PSEL), 64'(!partial && c >= 1 && c < resp));
            check_eq("penable", 64'(PENABLE), 64'(!partial && c >= 2 && c < resp));
            check_eq("r_valid", 64'(r_valid), 64'(c == resp));
            if (!partial && c >= 1 && c < resp) begin
                check_eq("paddr", 64'(PADDR), 64'(a));
                check_eq("pwrite", 64'(PWRITE), 64'(w));
                check_eq("pwdata", 64'(PWDATA), 64'(w ? wd : 32'h0));
            end
            if (c >= resp) begin
                check_eq("r_rdata", 64'(r_rdata), 64'(exp_rd));
                check_eq("r_id", 64'(r_id), 64'(i));
                if (c == resp) check_eq("r_opc", 64'(r_opc), 64'(exp_opc));
            end
            @(posedge clk_i);
            #1;
            if (c == 0) begin
                // Inputs are ignored after grant; scramble them.
                req = 1'b0; add = $urandom; we = 1'($urandom); wdata = $urandom;
                be = 4'($urandom); id = 5'($urandom);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req = 1'b0; add = '0; we = 1'b0; wdata = '0; be = '0; id = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_psel", 64'(PSEL), 64'd0);
        check_eq("rst_penable", 64'(PENABLE), 64'd0);
        check_eq("rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("rst_paddr", 64'(PADDR), 64'd0);
        check_eq("rst_pwdata", 64'(PWDATA), 64'd0);
        check_eq("rst_r_rdata", 64'(r_rdata), 64'd0);
        check_eq("rst_r_id", 64'(r_id), 64'd0);
        check_eq("rst_r_opc", 64'(r_opc), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed cases
        run_txn(32'h1A10_3004, 1'b0, 32'h0, 4'hF, 5'd5, 0, 32'h1234_5678, 1'b0);
        run_txn(32'h1A10_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 5'd9, 3, 32'h5555_AAAA, 1'b0);
        run_txn(32'h1A10_0010, 1'b0, 32'h0, 4'hF, 5'd17, 0, 32'hBAD0_0001, 1'b1);
        run_txn(32'h1A10_0020, 1'b0, 32'h0, 4'hF, 5'd2, 100, 32'h0BAD_0BAD, 1'b0);
        run_txn(32'h1A10_0024, 1'b0, 32'h0, 4'hF, 5'd3, 7, 32'h7777_0008, 1'b0);
        run_txn(32'h1A10_0028, 1'b1, 32'h1111_2222, 4'b0011, 5'd30, 0, 32'h0, 1'b0);

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            logic        rw;
            logic [3:0]  rb;
            rw = 1'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            run_txn($urandom, rw, $urandom, rb, 5'($urandom), $urandom_range(0, 9),
                    $urandom, 1'($urandom_range(0, 3) == 0));
        end

        // Back-to-back with req held: grants 4 cycles apart
        slv_waits = 0; slv_rdata = 32'hA5A5_0001; slv_err = 1'b0;
        req = 1'b1; add = 32'h40; we = 1'b0; be = 4'hF; id = 5'd11;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk_i);
            check_eq("b2b_gnt", 64'(gnt), 64'(c == 0 || c == 4));
            check_eq("b2b_r_valid", 64'(r_valid), 64'(c == 3 || c == 7));
            @(posedge clk_i);
            #1;
            if (c == 4) req = 1'b0;
        end

        // Reset during ACCESS
        slv_waits = 100;
        req = 1'b1; add = 32'h80; we = 1'b0; be = 4'hF; id = 5'd4;
        @(posedge clk_i);
        #1 req = 1'b0;
        @(posedge clk_i);
        #3;
        check_eq("pre_rst_penable", 64'(PENABLE), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_psel", 64'(PSEL), 64'd0);
        check_eq("mid_rst_penable", 64'(PENABLE), 64'd0);
        check_eq("mid_rst_r_valid", 64'(r_valid), 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            check_eq("post_rst_r_valid", 64'(r_valid), 64'd0);
            check_eq("post_rst_psel", 64'(PSEL), 64'd0);
        end
        @(posedge clk_i);
        #1;
        run_txn(32'h1A10_3008, 1'b0, 32'h0, 4'hF, 5'd6, 1, 32'hFEED_0006, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/per2apb.md
Name: per2apb

Overview:
- Bridges a peripheral-interconnect master onto an APB3 bus; it is the responder end of the req/gnt/r_valid per protocol.
- Accepts one per transaction at a time and issues the matching APB SETUP/ACCESS sequence.
- Returns read data and error status on the per response channel.
- Sits between the debug/peripheral interconnect and an APB slave segment, so per-side masters can reach APB peripherals.

Parameters:
- PER_ADDR_WIDTH, 32, width of per_slave_add_i.
- APB_ADDR_WIDTH, 32, width of PADDR. The address is zero-extended or truncated from PER_ADDR_WIDTH.
- PER_ID_WIDTH, 5, width of the transaction ID echoed in the response.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort. 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- per_slave_req_i  in  1  request valid
- per_slave_add_i  in  PER_ADDR_WIDTH  byte address
- per_slave_we_i  in  1  1=write, 0=read
- per_slave_wdata_i  in  32  write data
- per_slave_be_i  in  4  byte enables
- per_slave_id_i  in  PER_ID_WIDTH  transaction ID
- per_slave_gnt_o  out  1  request accepted
- per_slave_r_valid_o  out  1  response valid (single-cycle pulse)
- per_slave_r_opc_o  out  1  1=error
- per_slave_r_id_o  out  PER_ID_WIDTH  echoed ID
- per_slave_r_rdata_o  out  32  read data
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- One clock; reset is asynchronous and active-low. clk_i clocks the block; rst_ni resets it.
- Reset values: state=IDLE; all outputs 0, including PADDR, PWDATA, r_rdata and r_id. Reset mid-transfer drops PSEL/PENABLE immediately (asynchronous) and discards the pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - per_slave_gnt_o = per_slave_req_i, combinational. It is asserted only in IDLE.
  - On req, latch add, we, wdata, id into the request registers.
  - If we=1 and be!=4'hF: no APB access. Set opc=1 and rdata=0, go to RESP. APB3 has no strobes, so partial writes are rejected.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA driven from the latched registers; PWDATA=0 for reads.
  - Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - Timeout counter starts at 0 and increments each ACCESS cycle with PREADY=0.
  - On PREADY=1: capture rdata=PRDATA (reads; 0 for writes) and opc=PSLVERR, go to RESP.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0: set opc=1 and rdata=32'hDEADBEEF, deassert PSEL/PENABLE, go to RESP.
  - PREADY and timeout in the same cycle: PREADY wins.
- RESP (1 cycle):
  - r_valid=1, with r_opc, r_id and r_rdata valid. The per master cannot stall the response.
  - PSEL=0, PENABLE=0. Go to IDLE.
  - r_rdata and r_id hold their values after RESP until the next response.
- Latency:
  - Zero-wait APB: gnt in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, r_valid in cycle 3.
  - Each PREADY wait state adds one cycle.
  - The earliest next gnt is in cycle 4.
- The request inputs are ignored outside IDLE; the master must hold req until gnt.
- PADDR zero-extends when APB_ADDR_WIDTH>PER_ADDR_WIDTH and takes the low bits otherwise.

Test Plan:
- Zero-wait read: req add=0x1A10_3004, we=0, id=5, slave PRDATA=0x1234_5678 with PREADY=1 at first ACCESS -> gnt in cycle 0; PSEL in cycle 1; PENABLE in cycle 2; r_valid in cycle 3 with rdata=0x12345678, opc=0, id=5.
- Write with 3 wait states: add=0x1A10_0000, wdata=0xCAFE_F00D, be=4'hF -> PWRITE=1 and PWDATA stable for 4 ACCESS cycles; r_valid 6 cycles after gnt with opc=0, rdata=0.
- Slave error: read with PSLVERR=1 and PREADY=1 -> r_opc=1, rdata=PRDATA.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0 -> PSEL drops after 8 ACCESS cycles; r_valid with opc=1, rdata=0xDEADBEEF.
- PREADY coinciding with timeout: PREADY rises on the 8th ACCESS cycle -> opc=0, real PRDATA returned.
- Partial write: be=4'b0011 -> gnt, no PSEL ever asserted; r_valid 1 cycle later with opc=1.
- Back-to-back: req held high for two transactions -> second gnt exactly 4 cycles after the first (zero-wait).
- Reset mid-transfer: assert rst_ni=0 during ACCESS -> PSEL, PENABLE and r_valid go 0 immediately; after release the block is IDLE with no spurious response.
